// File: rtl/lcd_img_if.sv
// Command host, IROM and IRAM signals of the image controller.
// master is the controller side; slave is the host/memory side.
interface lcd_img_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic          done;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic [DW-1:0] IROM_Q;
  logic          IRAM_valid;
  logic [AW-1:0] IRAM_A;
  logic [DW-1:0] IRAM_D;

  modport master (
    input  cmd, cmd_valid, IROM_Q,
    output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
  );
  modport slave (
    output cmd, cmd_valid, IROM_Q,
    input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D
  );
endinterface

// File: rtl/lcd_img_ctrl.sv
// Image controller: loads a 2^AW_X x 2^AW_Y image from IROM, edits a 2x2 window
// around the op point on command, and streams the whole image to IRAM on WRITE.
module lcd_img_ctrl #(
  parameter int DW        = 8,
  parameter int AW_X      = 3,
  parameter int AW_Y      = 3,
  parameter int ROUND_AVG = 0
) (
  input  logic      clk,
  input  logic      reset,
  lcd_img_if.master bus
);
  localparam int AW   = AW_X + AW_Y;
  localparam int NPIX = 1 << AW;
  localparam logic [AW_X-1:0] X_C   = {1'b1, {(AW_X-1){1'b0}}};
  localparam logic [AW_Y-1:0] Y_C   = {1'b1, {(AW_Y-1){1'b0}}};
  localparam logic [AW_X-1:0] X_ONE = AW_X'(1);
  localparam logic [AW_Y-1:0] Y_ONE = AW_Y'(1);
  localparam logic [AW:0]     C_ONE = (AW+1)'(1);
  localparam logic [DW+1:0]   RND   = (ROUND_AVG != 0) ? (DW+2)'(2) : '0;

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW_X-1:0]         x_q, x_d;
  logic [AW_Y-1:0]         y_q, y_d;
  logic [3:0]              cmd_q, cmd_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic [NPIX-1:0][DW-1:0] pix_q, pix_d;
  logic                    rd_q, rd_d, cap_q, cap_d, wv_q, wv_d;
  logic                    done_q, done_d, busy_q, busy_d;
  logic [AW-1:0]           rom_a_q, rom_a_d, cap_a_q, cap_a_d, wa_q, wa_d;
  logic [DW-1:0]           wd_q, wd_d;

  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic [DW-1:0] p_tl, p_tr, p_bl, p_br, mx, mn, avg;
  logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
  logic [DW+1:0] sum;

  assign a_tl = {y_q - Y_ONE, x_q - X_ONE};
  assign a_tr = {y_q - Y_ONE, x_q};
  assign a_bl = {y_q,         x_q - X_ONE};
  assign a_br = {y_q,         x_q};
  assign p_tl = pix_q[a_tl];
  assign p_tr = pix_q[a_tr];
  assign p_bl = pix_q[a_bl];
  assign p_br = pix_q[a_br];

  always_comb begin
    mx = p_tl;
    if (p_tr > mx) mx = p_tr;
    if (p_bl > mx) mx = p_bl;
    if (p_br > mx) mx = p_br;
    mn = p_tl;
    if (p_tr < mn) mn = p_tr;
    if (p_bl < mn) mn = p_bl;
    if (p_br < mn) mn = p_br;
    // two guard bits: four DW-bit pixels plus rounding never overflow
    sum = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br} + RND;
    avg = sum[DW+1:2];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    rd_d    = 1'b0;
    rom_a_d = rom_a_q;
    cap_d   = rd_q;
    cap_a_d = rom_a_q;
    wv_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    n_tl    = p_tl;
    n_tr    = p_tr;
    n_bl    = p_bl;
    n_br    = p_br;
    // ROM data lands one cycle after its address; cap_* tracks that address
    if (cap_q) pix_d[cap_a_q] = bus.IROM_Q;
    case (state_q)
      S_LOAD: begin
        if (!cnt_q[AW]) begin
          rd_d    = 1'b1;
          rom_a_d = cnt_q[AW-1:0];
          cnt_d   = cnt_q + C_ONE;
        end
        if (cap_q && (cap_a_q == '1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            4'h0: begin
              state_d = S_WRITE;
              wv_d    = 1'b1;
              wa_d    = '0;
              wd_d    = pix_q[0];
              cnt_d   = C_ONE;
            end
            4'hC: begin
              state_d = S_LOAD;
              cnt_d   = '0;
              x_d     = X_C;
              y_d     = Y_C;
            end
            default: begin
              state_d = S_EXEC;
              cmd_d   = bus.cmd;
            end
          endcase
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (cmd_q)
          4'h1: if (y_q != Y_ONE) y_d = y_q - Y_ONE;
          4'h2: if (y_q != '1)    y_d = y_q + Y_ONE;
          4'h3: if (x_q != X_ONE) x_d = x_q - X_ONE;
          4'h4: if (x_q != '1)    x_d = x_q + X_ONE;
          4'h5: begin n_tl = mx;  n_tr = mx;  n_bl = mx;  n_br = mx;  end
          4'h6: begin n_tl = mn;  n_tr = mn;  n_bl = mn;  n_br = mn;  end
          4'h7: begin n_tl = avg; n_tr = avg; n_bl = avg; n_br = avg; end
          4'h8: begin n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
          4'h9: begin n_tl = p_bl; n_bl = p_br; n_br = p_tr; n_tr = p_tl; end
          4'hA: begin n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; end
          4'hB: begin n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
          4'hD: begin n_tl = ~p_tl; n_tr = ~p_tr; n_bl = ~p_bl; n_br = ~p_br; end
          default: ;
        endcase
        pix_d[a_tl] = n_tl;
        pix_d[a_tr] = n_tr;
        pix_d[a_bl] = n_bl;
        pix_d[a_br] = n_br;
      end
      S_WRITE: begin
        if (cnt_q[AW]) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wv_d  = 1'b1;
          wa_d  = cnt_q[AW-1:0];
          wd_d  = pix_q[cnt_q[AW-1:0]];
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_LOAD;
      x_q     <= X_C;
      y_q     <= Y_C;
      cmd_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      rom_a_q <= '0;
      cap_q   <= 1'b0;
      cap_a_q <= '0;
      wv_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rom_a_q <= rom_a_d;
      cap_q   <= cap_d;
      cap_a_q <= cap_a_d;
      wv_q    <= wv_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
    pix_q <= pix_d;
  end

  assign bus.IROM_rd    = rd_q;
  assign bus.IROM_A     = rom_a_q;
  assign bus.IRAM_valid = wv_q;
  assign bus.IRAM_A     = wa_q;
  assign bus.IRAM_D     = wd_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_lcd_img_ctrl.sv
// Directed bench: two 8x8 controllers (AVG floor / rounded) in lockstep plus a 16x8, 10-bit one.
module tb_lcd_img_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_img_if #(.DW(8),  .AW(6)) if0 ();
  lcd_img_if #(.DW(8),  .AW(6)) if1 ();
  lcd_img_if #(.DW(10), .AW(7)) if2 ();

  lcd_img_ctrl #(.DW(8),  .AW_X(3), .AW_Y(3), .ROUND_AVG(0)) u0 (.clk(clk), .reset(reset), .bus(if0.master));
  lcd_img_ctrl #(.DW(8),  .AW_X(3), .AW_Y(3), .ROUND_AVG(1)) u1 (.clk(clk), .reset(reset), .bus(if1.master));
  lcd_img_ctrl #(.DW(10), .AW_X(4), .AW_Y(3), .ROUND_AVG(0)) u2 (.clk(clk), .reset(reset), .bus(if2.master));

  assign if1.cmd       = if0.cmd;
  assign if1.cmd_valid = if0.cmd_valid;

  logic [7:0] rom0 [64];
  logic [9:0] rom2 [128];
  logic [7:0] ea [64];
  logic [7:0] eb [64];
  logic [9:0] e2 [128];
  int n_chk = 0;
  int n_err = 0;

  always @(posedge clk) if (if0.IROM_rd) if0.IROM_Q <= rom0[if0.IROM_A];
  always @(posedge clk) if (if1.IROM_rd) if1.IROM_Q <= rom0[if1.IROM_A];
  always @(posedge clk) if (if2.IROM_rd) if2.IROM_Q <= rom2[if2.IROM_A];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (if0.busy && n < 400) begin @(negedge clk); n++; end
    chk("idle_wait_a", 32'({if0.busy, if1.busy}), 32'(0));
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (if2.busy && n < 400) begin @(negedge clk); n++; end
    chk("idle_wait_b", 32'(if2.busy), 32'(0));
  endtask

  task automatic load_exp_a();
    for (int i = 0; i < 64; i++) begin ea[i] = rom0[i]; eb[i] = rom0[i]; end
  endtask

  task automatic ex_a(input logic [3:0] c);
    @(negedge clk); if0.cmd = c; if0.cmd_valid = 1'b1;
    @(negedge clk); if0.cmd_valid = 1'b0;
    chk("exec_busy_a", 32'({if0.busy, if1.busy}), 32'(2'b11));
    @(negedge clk);
    chk("exec_free_a", 32'({if0.busy, if1.busy}), 32'(0));
  endtask

  task automatic ex_b(input logic [3:0] c);
    @(negedge clk); if2.cmd = c; if2.cmd_valid = 1'b1;
    @(negedge clk); if2.cmd_valid = 1'b0;
    chk("exec_busy_b", 32'(if2.busy), 32'(1));
    @(negedge clk);
    chk("exec_free_b", 32'(if2.busy), 32'(0));
  endtask

  task automatic reload_a();
    @(negedge clk); if0.cmd = 4'hC; if0.cmd_valid = 1'b1;
    @(negedge clk); if0.cmd_valid = 1'b0;
    wait_idle_a();
    load_exp_a();
  endtask

  // hold=1 keeps an SR command asserted for the whole burst; it must be ignored
  task automatic wr_a(input bit hold);
    @(negedge clk); if0.cmd = 4'h0; if0.cmd_valid = 1'b1;
    @(negedge clk); if0.cmd = hold ? 4'h4 : 4'h0; if0.cmd_valid = hold;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      chk("beat_a", 32'({if0.IRAM_valid, if0.IRAM_A, if0.IRAM_D, if1.IRAM_valid, if1.IRAM_A, if1.IRAM_D}),
          32'({1'b1, 6'(i), ea[i], 1'b1, 6'(i), eb[i]}));
    end
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    chk("done_a", 32'({if0.done, if0.busy, if0.IRAM_valid, if1.done, if1.busy}), 32'(5'b11011));
    @(negedge clk);
    chk("after_done_a", 32'({if0.done, if0.busy, if1.done, if1.busy}), 32'(0));
  endtask

  task automatic wr_b();
    @(negedge clk); if2.cmd = 4'h0; if2.cmd_valid = 1'b1;
    @(negedge clk); if2.cmd_valid = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (i > 0) @(negedge clk);
      chk("beat_b", 32'({if2.IRAM_valid, if2.IRAM_A, if2.IRAM_D}), 32'({1'b1, 7'(i), e2[i]}));
    end
    @(negedge clk);
    chk("done_b", 32'({if2.done, if2.busy, if2.IRAM_valid}), 32'(3'b110));
    @(negedge clk);
    chk("after_done_b", 32'({if2.done, if2.busy}), 32'(0));
  endtask

  initial begin
    int n;
    if0.cmd = 4'h0; if0.cmd_valid = 1'b0;
    if2.cmd = 4'h0; if2.cmd_valid = 1'b0;
    for (int i = 0; i < 64; i++)  rom0[i] = 8'(i);
    for (int i = 0; i < 128; i++) rom2[i] = 10'(i * 7 + 3);

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_a", 32'({if0.busy, if0.IROM_rd, if0.IRAM_valid, if0.done, if0.IROM_A, if0.IRAM_A, if0.IRAM_D}),
        32'({4'b1000, 20'd0}));
    chk("rst_b", 32'({if2.busy, if2.IROM_rd, if2.IRAM_valid, if2.done, if2.IROM_A, if2.IRAM_A, if2.IRAM_D}),
        32'({4'b1000, 24'd0}));
    reset = 1'b1;
    @(negedge clk);
    chk("load_start", 32'({if0.IROM_rd, if0.IROM_A, if2.IROM_rd, if2.IROM_A}), 32'({1'b1, 6'd0, 1'b1, 7'd0}));

    // 16x8, 10-bit instance
    wait_idle_b();
    for (int i = 0; i < 128; i++) e2[i] = rom2[i];
    wr_b();
    ex_b(4'h5);                        // centre (8,4): pixels 55,56,71,72 -> rom2[72]=507
    e2[55] = 10'd507; e2[56] = 10'd507; e2[71] = 10'd507; e2[72] = 10'd507;
    wr_b();
    repeat (10) ex_b(4'h4);            // x saturates at 15
    ex_b(4'h5);                        // pixels 62,63,78,79 -> rom2[79]=556
    e2[62] = 10'd556; e2[63] = 10'd556; e2[78] = 10'd556; e2[79] = 10'd556;
    wr_b();
    @(negedge clk); if2.cmd = 4'hC; if2.cmd_valid = 1'b1;
    @(negedge clk); if2.cmd_valid = 1'b0;
    n = 0;
    while (if2.busy && n < 400) begin @(negedge clk); n++; end
    chk("reload_busy_b", 32'(n >= 128 && n < 400), 32'(1));
    for (int i = 0; i < 128; i++) e2[i] = rom2[i];
    ex_b(4'h5);
    e2[55] = 10'd507; e2[56] = 10'd507; e2[71] = 10'd507; e2[72] = 10'd507;
    wr_b();

    // 8x8 pair: plain image, then saturation at the top-left corner
    wait_idle_a();
    load_exp_a();
    wr_a(1'b0);
    repeat (5) ex_a(4'h1);
    repeat (5) ex_a(4'h3);
    ex_a(4'h5);
    ea[0] = 8'd9; ea[1] = 8'd9; ea[8] = 8'd9; ea[9] = 8'd9;
    eb[0] = 8'd9; eb[1] = 8'd9; eb[8] = 8'd9; eb[9] = 8'd9;
    wr_a(1'b0);

    // AVG rounding and the all-0xFF window
    rom0[27] = 8'd1; rom0[28] = 8'd2; rom0[35] = 8'd2; rom0[36] = 8'd2;
    rom0[51] = 8'hFF; rom0[52] = 8'hFF; rom0[59] = 8'hFF; rom0[60] = 8'hFF;
    reload_a();
    ex_a(4'h7);
    ea[27] = 8'd1; ea[28] = 8'd1; ea[35] = 8'd1; ea[36] = 8'd1;
    eb[27] = 8'd2; eb[28] = 8'd2; eb[35] = 8'd2; eb[36] = 8'd2;
    repeat (5) ex_a(4'h2);             // y saturates at 7: window 51,52,59,60
    ex_a(4'h7);
    wr_a(1'b0);

    // SR held during WRITE must not move the op point
    rom0[27] = 8'd10; rom0[28] = 8'd20; rom0[35] = 8'd30; rom0[36] = 8'd40;
    reload_a();
    wr_a(1'b1);
    ex_a(4'h5);
    ea[27] = 8'd40; ea[28] = 8'd40; ea[35] = 8'd40; ea[36] = 8'd40;
    eb[27] = 8'd40; eb[28] = 8'd40; eb[35] = 8'd40; eb[36] = 8'd40;
    wr_a(1'b0);

    // rotations, mirrors, invert, min, no-op
    reload_a();
    ex_a(4'h9);
    ea[27] = 8'd30; ea[28] = 8'd10; ea[35] = 8'd40; ea[36] = 8'd20;
    eb[27] = 8'd30; eb[28] = 8'd10; eb[35] = 8'd40; eb[36] = 8'd20;
    wr_a(1'b0);
    ex_a(4'h8);
    ex_a(4'hE);
    load_exp_a();
    wr_a(1'b0);
    ex_a(4'hA);
    ex_a(4'hB);
    ea[27] = 8'd40; ea[28] = 8'd30; ea[35] = 8'd20; ea[36] = 8'd10;
    eb[27] = 8'd40; eb[28] = 8'd30; eb[35] = 8'd20; eb[36] = 8'd10;
    wr_a(1'b0);
    ex_a(4'hD);
    ea[27] = 8'd215; ea[28] = 8'd225; ea[35] = 8'd235; ea[36] = 8'd245;
    eb[27] = 8'd215; eb[28] = 8'd225; eb[35] = 8'd235; eb[36] = 8'd245;
    wr_a(1'b0);
    ex_a(4'h6);
    ea[28] = 8'd215; ea[35] = 8'd215; ea[36] = 8'd215;
    eb[28] = 8'd215; eb[35] = 8'd215; eb[36] = 8'd215;
    wr_a(1'b0);

    // reset at beat 20 aborts the burst and restarts the load
    @(negedge clk); if0.cmd = 4'h0; if0.cmd_valid = 1'b1;
    @(negedge clk); if0.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("beat20", 32'({if0.IRAM_valid, if0.IRAM_A}), 32'({1'b1, 6'd20}));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_abort", 32'({if0.IRAM_valid, if0.busy, if1.IRAM_valid}), 32'(3'b010));
    reset = 1'b1;
    @(negedge clk);
    chk("rom_restart", 32'({if0.IROM_rd, if0.IROM_A}), 32'({1'b1, 6'd0}));
    wait_idle_a();
    load_exp_a();
    wr_a(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
